// File: rtl/seq_add_sub_pkg.sv
// Shared definitions for the chunked adder/subtractor: FSM encoding, index sizing
// and the single-bit full adder the chunk ripple is built from.
package seq_add_sub_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Index counter needs at least one bit even when the whole word is one chunk.
    function automatic int idx_width(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

    // Returns {carry_out, sum}.
    function automatic logic [1:0] full_adder_one_bit(input logic x, input logic y, input logic ci);
        logic s;
        logic co;
        s  = x ^ y ^ ci;
        co = (x & y) | (x & ci) | (y & ci);
        return {co, s};
    endfunction

endpackage

// File: rtl/add_sub_chunk.sv
// Combinational CHUNK-bit ripple adder; also reports the carry into its MSB so the
// top level can derive signed overflow on the final chunk.
module add_sub_chunk
    import seq_add_sub_pkg::*;
#(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [CHUNK:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        assign {c[i+1], sum[i]} = full_adder_one_bit(a[i], b[i], c[i]);
    end

    assign cout  = c[CHUNK];
    assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/seq_add_sub.sv
// Multi-cycle two's-complement add/sub: one CHUNK-bit slice per clock, LSB first,
// carry registered between slices; start/busy/done handshake with registered flags.
module seq_add_sub
    import seq_add_sub_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow,
    output logic             zero,
    output state_t           dbg_state
);

    // Handshake: start is taken on a rising edge only while busy is low (a, b, sub
    // captured on that same edge); busy stays high for NCHUNK cycles; done pulses for
    // exactly one cycle with busy low, and start may be raised in that very cycle.

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = idx_width(NCHUNK);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] bx_q;
    logic             carry_q;
    logic [IDXW-1:0]  idx;

    logic [CHUNK-1:0] chunk_sum;
    logic             chunk_cout;
    logic             chunk_c_msb;
    logic [WIDTH-1:0] res_next;
    logic [31:0]      base;

    // Operands shift right each cycle so the adder always sees the low slice.
    add_sub_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a     (a_q[CHUNK-1:0]),
        .b     (bx_q[CHUNK-1:0]),
        .cin   (carry_q),
        .sum   (chunk_sum),
        .cout  (chunk_cout),
        .c_msb (chunk_c_msb)
    );

    always_comb begin
        base     = 32'(idx) * 32'(CHUNK);
        res_next = result;
        res_next[base +: CHUNK] = chunk_sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            a_q      <= '0;
            bx_q     <= '0;
            carry_q  <= 1'b0;
            idx      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        bx_q    <= b ^ {WIDTH{sub}};
                        carry_q <= sub;
                        idx     <= '0;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    result  <= res_next;
                    carry_q <= chunk_cout;
                    a_q     <= a_q >> CHUNK;
                    bx_q    <= bx_q >> CHUNK;
                    idx     <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        cout     <= chunk_cout;
                        overflow <= chunk_c_msb ^ chunk_cout;
                        zero     <= (res_next == '0);
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        idx      <= '0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign dbg_state = state;

endmodule
